// File: rtl/mips_muldiv_unit.sv
// mips_muldiv_unit: iterative MULT/MULTU/DIV/DIVU unit owning the architectural HI/LO registers.
// Ports: clk/rst (sync, active-low); start/op/op_a/op_b issue an operation; hi_we/lo_we/wdata
//   perform MTHI/MTLO; busy stalls the core, done pulses when an operation writes HI/LO,
//   div_zero is sticky for the last divide, hi/lo feed the MFHI/MFLO writeback path.
// Latency: 33 cycles from start to done for every op (one bit per cycle plus a fix-up cycle).
// Optional macro MULDIV_DIV_EN: when undefined the divider is removed and DIV/DIVU
//   complete in one cycle without touching HI/LO.
module mips_muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;

  logic [1:0]         state;
  logic [CNT_W-1:0]   cnt;
  // Multiply: acc = {partial product, remaining multiplier bits}.
  // Divide:   acc = {partial remainder, remaining dividend bits / quotient bits}.
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_nxt;
  logic [WIDTH-1:0]   m_reg;   // multiplicand or divisor magnitude
  logic               div_op;
  logic               neg_q;   // product / quotient sign

  logic               sign_a;
  logic               sign_b;
  logic [WIDTH-1:0]   abs_a;
  logic [WIDTH-1:0]   abs_b;
  logic [WIDTH:0]     add_sum;
  logic [2*WIDTH-1:0] prod;

  assign sign_a = op[0] & op_a[WIDTH-1];
  assign sign_b = op[0] & op_b[WIDTH-1];
  assign abs_a  = sign_a ? -op_a : op_a;
  assign abs_b  = sign_b ? -op_b : op_b;
  assign busy   = (state != S_IDLE);
  assign prod   = neg_q ? -acc : acc;

`ifdef MULDIV_DIV_EN
  logic               neg_r;   // remainder takes the dividend sign
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH:0]     diff;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem_fix;

  assign quo     = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign rem_fix = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
`endif

  always_comb begin
    // Shift-add step: conditionally add the multiplicand into the upper half, then shift right.
    add_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, {WIDTH{acc[0]}} & m_reg};
    acc_nxt = {add_sum, acc[WIDTH-1:1]};
`ifdef MULDIV_DIV_EN
    // Restoring step: bring down the next dividend bit and trial-subtract the divisor.
    // Borrow out (diff MSB) means the trial failed and the remainder is kept.
    rem_sh = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    diff   = rem_sh - {1'b0, m_reg};
    if (div_op) begin
      if (!diff[WIDTH]) acc_nxt = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      else              acc_nxt = {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= S_IDLE;
      done     <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      cnt      <= '0;
      acc      <= '0;
      m_reg    <= '0;
      div_op   <= 1'b0;
      neg_q    <= 1'b0;
`ifdef MULDIV_DIV_EN
      neg_r    <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (hi_we) hi <= wdata;
          if (lo_we) lo <= wdata;
          if (start) begin
            div_op <= op[1];
            neg_q  <= sign_a ^ sign_b;
`ifdef MULDIV_DIV_EN
            neg_r  <= sign_a;
`endif
            cnt    <= CNT_W'(WIDTH - 1);
            if (op[1]) begin
              m_reg <= abs_b;
              acc   <= {{WIDTH{1'b0}}, abs_a};
            end else begin
              m_reg <= abs_a;
              acc   <= {{WIDTH{1'b0}}, abs_b};
            end
`ifdef MULDIV_DIV_EN
            state <= S_CALC;
`else
            state <= op[1] ? S_FIN : S_CALC;
`endif
          end
        end
        S_CALC: begin
          acc <= acc_nxt;
          if (cnt == '0) state <= S_FIN;
          else           cnt   <= cnt - CNT_W'(1);
        end
        S_FIN: begin
          done  <= 1'b1;
          state <= S_IDLE;
          if (!div_op) begin
            {hi, lo} <= prod;
          end
`ifdef MULDIV_DIV_EN
          else if (m_reg == '0) begin
            // Divide by zero: remainder path already holds |op_a|, so the sign fix restores op_a.
            lo       <= '1;
            hi       <= rem_fix;
            div_zero <= 1'b1;
          end else begin
            lo       <= quo;
            hi       <= rem_fix;
            div_zero <= 1'b0;
          end
`endif
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
